// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
// Parity support is compiled in only when UART_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_RECOVER
  } rx_state_t;

  // Parity bit value that makes XOR(data, parity) equal to odd.
  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick divider; a cfg_div of 0 divides by 1.
module uart_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  always_comb last = (cfg_div == '0) ? '0 : cfg_div - 1'b1;

  // >= so that shrinking cfg_div at runtime never strands the counter past terminal
  assign tick = (cnt >= last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_core.sv
// UART transceiver: TX/RX FSMs, 16x-oversampled majority-vote RX, holding register.
// Define UART_PARITY_EN to build the optional parity bit and rx_parity_err.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic                 cfg_stop2,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic tick;

  uart_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_div (cfg_div),
    .tick    (tick)
  );

  // ---------------- TX ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [TW-1:0]        tx_tcnt, tx_tcnt_n;
  logic [BW-1:0]        tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_stop2, tx_stop2_n;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_en, tx_par_en_n, tx_par, tx_par_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_stop2 <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_en <= 1'b0;
      tx_par    <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_stop2 <= tx_stop2_n;
`ifdef UART_PARITY_EN
      tx_par_en <= tx_par_en_n;
      tx_par    <= tx_par_n;
`endif
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_stop2_n = tx_stop2;
`ifdef UART_PARITY_EN
    tx_par_en_n = tx_par_en;
    tx_par_n    = tx_par;
`endif
    tx_bit_end = tick && (tx_tcnt == T_LAST);
    if (tick) tx_tcnt_n = tx_bit_end ? '0 : tx_tcnt + 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        tx_tcnt_n = '0;
        if (tx_valid) begin
          tx_state_n = TX_START;
          tx_bit_n   = '0;
          tx_sh_n    = tx_data;
          tx_stop2_n = cfg_stop2;
`ifdef UART_PARITY_EN
          tx_par_en_n = cfg_parity_en;
          tx_par_n    = parity_calc(8'(tx_data), cfg_parity_odd);
`endif
        end
      end
      TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_sh_n  = tx_sh >> 1;
        tx_bit_n = tx_bit + 1'b1;
        if (tx_bit == B_LAST) begin
          tx_bit_n   = '0;
          tx_state_n = TX_STOP;
`ifdef UART_PARITY_EN
          if (tx_par_en) tx_state_n = TX_PARITY;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
`endif
      TX_STOP: if (tx_bit_end) begin
        if (tx_stop2 && tx_bit == '0) tx_bit_n = BW'(1);
        else                          tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    unique case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_sh[0];
`ifdef UART_PARITY_EN
      TX_PARITY: txd = tx_par;
`endif
      default:  txd = 1'b1;
    endcase
  end

  assign tx_ready = (tx_state == TX_IDLE);

  // ---------------- RX ----------------
  rx_state_t            rx_state, rx_state_n;
  logic [1:0]           rx_sync;
  logic                 rx_prev, rx_s, rx_fall, rx_maj;
  logic [TW-1:0]        rx_tcnt, rx_tcnt_n;
  logic [BW-1:0]        rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_s0, rx_s0_n, rx_s1, rx_s1_n;
  logic                 rx_bit_end, rx_mid, rx_done, rx_perr_c;
`ifdef UART_PARITY_EN
  logic                 rx_par_en, rx_par_en_n, rx_par_odd, rx_par_odd_n, rx_par, rx_par_n;
  logic                 rx_perr_q;
`else
  logic                 unused_cfg_parity;
  assign unused_cfg_parity = cfg_parity_en ^ cfg_parity_odd;
`endif

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev & ~rx_s;
  assign rx_maj  = (rx_s0 & rx_s1) | (rx_s0 & rx_s) | (rx_s1 & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_s0    <= 1'b1;
      rx_s1    <= 1'b1;
`ifdef UART_PARITY_EN
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par     <= 1'b0;
`endif
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_s0    <= rx_s0_n;
      rx_s1    <= rx_s1_n;
`ifdef UART_PARITY_EN
      rx_par_en  <= rx_par_en_n;
      rx_par_odd <= rx_par_odd_n;
      rx_par     <= rx_par_n;
`endif
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_s0_n    = rx_s0;
    rx_s1_n    = rx_s1;
    rx_done    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_en_n  = rx_par_en;
    rx_par_odd_n = rx_par_odd;
    rx_par_n     = rx_par;
`endif
    rx_bit_end = tick && (rx_tcnt == T_LAST);
    rx_mid     = tick && (rx_tcnt == T_S2);
    if (tick && rx_tcnt == T_S0) rx_s0_n = rx_s;
    if (tick && rx_tcnt == T_S1) rx_s1_n = rx_s;
    if (tick) rx_tcnt_n = rx_bit_end ? '0 : rx_tcnt + 1'b1;
    unique case (rx_state)
      RX_IDLE: begin
        rx_tcnt_n = '0;
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_bit_n   = '0;
`ifdef UART_PARITY_EN
          rx_par_en_n  = cfg_parity_en;
          rx_par_odd_n = cfg_parity_odd;
`endif
        end
      end
      RX_START: begin
        if (rx_mid && rx_maj) begin
          rx_state_n = RX_IDLE;
          rx_tcnt_n  = '0;
        end else if (rx_bit_end) begin
          rx_state_n = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_mid) rx_sh_n = {rx_maj, rx_sh[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          rx_bit_n = rx_bit + 1'b1;
          if (rx_bit == B_LAST) begin
            rx_bit_n   = '0;
            rx_state_n = RX_STOP;
`ifdef UART_PARITY_EN
            if (rx_par_en) rx_state_n = RX_PARITY;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_mid) rx_par_n = rx_maj;
        if (rx_bit_end) rx_state_n = RX_STOP;
      end
`endif
      RX_STOP: if (rx_mid) begin
        rx_done    = 1'b1;
        rx_tcnt_n  = '0;
        rx_state_n = rx_maj ? RX_IDLE : RX_RECOVER;
      end
      // Counts ticks of continuously-high line; any low sample restarts the bit
      RX_RECOVER: begin
        if (!rx_s)           rx_tcnt_n  = '0;
        else if (rx_bit_end) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  assign rx_perr_c     = rx_par_en && (rx_par != parity_calc(8'(rx_sh), rx_par_odd));
  assign rx_parity_err = rx_perr_q;
`else
  assign rx_perr_c     = 1'b0;
  assign rx_parity_err = 1'b0;
`endif

  // A byte completing in the same cycle as a pop replaces the held one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q    <= 1'b0;
`endif
    end else begin
      rx_overrun <= rx_done && rx_valid && !rx_ready;
      if (rx_done && (!rx_valid || rx_ready)) begin
        rx_data      <= rx_sh;
        rx_frame_err <= ~rx_maj;
        rx_valid     <= 1'b1;
`ifdef UART_PARITY_EN
        rx_perr_q    <= rx_perr_c;
`endif
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
